fetch_pc_gen: RTL
=================

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 SHALL have parameter BOOT_VECTOR, default 32'h80000000, meaning the first fetch PC after reset.
REQ-002 SHALL have port clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port branch_request_i  in  1  redirect request from execute/CSR.
REQ-005 SHALL have port branch_pc_i  in  32  redirect target PC.
REQ-006 SHALL have port next_pc_f_i  in  32  predictor next PC for the current pc_f_o.
REQ-007 SHALL have port next_taken_f_i  in  2  predictor taken flags, bit0 = slot0, bit1 = slot1.
REQ-008 SHALL have port pc_f_o  out  32  PC currently being requested, for predictor lookup.
REQ-009 SHALL have port pc_accept_o  out  1  pc_f_o accepted by the icache this cycle.
REQ-010 SHALL have port icache_rd_o  out  1  icache read request.
REQ-011 SHALL have port icache_pc_o  out  32  request address, {pc_f_o[31:3],3'b000}.
REQ-012 SHALL have port icache_accept_i  in  1  icache takes the request.
REQ-013 SHALL have port icache_valid_i  in  1  response valid.
REQ-014 SHALL have port icache_inst_i  in  64  two instructions; slot0 = [31:0].
REQ-015 SHALL have port icache_error_i  in  1  bus error on the response.
REQ-016 SHALL have port icache_page_fault_i  in  1  page fault on the response.
REQ-017 SHALL have port fetch_valid_o  out  1  bundle valid to decode.
REQ-018 SHALL have port fetch_instr_o  out  64  instruction pair.
REQ-019 SHALL have port fetch_pc_o  out  32  PC of the bundle.
REQ-020 SHALL have port fetch_pred_branch_o  out  2  taken prediction carried with the bundle.
REQ-021 SHALL have port fetch_fault_fetch_o  out  1  bus-error flag for the bundle.
REQ-022 SHALL have port fetch_fault_page_o  out  1  page-fault flag for the bundle.
REQ-023 SHALL have port fetch_accept_i  in  1  decode accepts the bundle.

Function
REQ-024 SHALL allow at most one outstanding icache request; outstanding_q sets on icache_rd_o&icache_accept_i and clears on icache_valid_i.
REQ-025 SHALL assert icache_rd_o = active_q & ~skid_valid_q & ~(outstanding_q & ~icache_valid_i) & ~branch_request_i.
REQ-026 SHALL set active_q one cycle after reset deassertion, so the first request issues in cycle 2.
REQ-027 SHALL on accept (pc_accept_o = icache_rd_o & icache_accept_i) latch the pc_f_o and prediction of the issued request into a pending register.
REQ-028 SHALL on accept advance pc_f_o to {pc_f_o[31:3]+1,3'b000}, wrapping 32'hFFFFFFF8 -> 32'h00000000.
REQ-029 SHALL drive fetch_valid_o = skid_valid_q | (icache_valid_i & ~discard_q & ~branch_request_i), sourcing the bundle from skid when it is valid.
REQ-030 SHALL pass fetch_instr_o through unmodified on faults; fault flags copy icache_error_i / icache_page_fault_i.
REQ-031 SHALL capture the response into the skid buffer when it is valid, not discarded and fetch_accept_i=0; the skid SHALL clear when fetch_accept_i=1.
REQ-032 SHALL hold all fetch_* outputs stable while fetch_valid_o=1 and fetch_accept_i=0.
REQ-033 SHALL on branch_request_i set pc_f_o <= branch_pc_i, clear skid_valid_q, and drop any same-cycle response.
REQ-034 SHALL on branch_request_i set discard_q if a request is outstanding and no response arrives that cycle.
REQ-035 SHALL drop the next response while discard_q=1, then clear discard_q.
REQ-036 SHALL let the last of several back-to-back branch requests win.

Reset
REQ-037 SHALL reset pc_f_o=BOOT_VECTOR and active_q, outstanding_q, discard_q, skid_valid_q=0.
REQ-038 SHALL reset all fetch_* outputs to 0, icache_rd_o=0 and pc_accept_o=0.
REQ-039 SHALL on reset mid-request abandon the request; a response arriving after reset release SHALL be ignored (discard_q semantics).

Configuration
REQ-040 SHALL, with FETCH_BPRED_EN defined, take the next PC from next_pc_f_i and the prediction from next_taken_f_i.
REQ-041 SHALL, without FETCH_BPRED_EN, use the sequential next PC, drive fetch_pred_branch_o=2'b00, and ignore the predictor inputs.

Verification
REQ-042 SHALL cover: reset release, icache always ready, 1-cycle latency -> requests at 0x80000000, 0x80000008, 0x80000010; fetch_valid_o every cycle from cycle 3.
REQ-043 SHALL cover: fetch_accept_i=0 for 3 cycles during a response -> skid holds the bundle and instr/pc are stable; no new icache_rd_o until the skid drains.
REQ-044 SHALL cover: branch_request_i to 0x80001004 while a request is outstanding -> stale response dropped; next request at 0x80001000 (icache_pc_o).
REQ-045 SHALL cover: pc_f_o=0xFFFFFFF8 accepted -> next pc_f_o=0x00000000.
REQ-046 SHALL cover: a response with icache_page_fault_i=1 -> fetch_fault_page_o=1 with the PC of that request.
REQ-047 SHALL cover: FETCH_BPRED_EN defined, next_pc_f_i=0x80000100, next_taken_f_i=2'b01 -> next request at 0x80000100 and the bundle carries pred=2'b01.

Source files
------------

// File: rtl/fetch_pc_gen_if.sv
// Fetch-stage bus bundle: icache request/response channel plus the
// instruction-bundle channel towards decode. The master side is the fetch
// PC generator; the slave side is the icache/decode environment.
interface fetch_pc_gen_if;
   // icache request / response
   logic        icache_rd_o;
   logic [31:0] icache_pc_o;
   logic        icache_accept_i;
   logic        icache_valid_i;
   logic [63:0] icache_inst_i;
   logic        icache_error_i;
   logic        icache_page_fault_i;
   // bundle towards decode
   logic        fetch_valid_o;
   logic [63:0] fetch_instr_o;
   logic [31:0] fetch_pc_o;
   logic [1:0]  fetch_pred_branch_o;
   logic        fetch_fault_fetch_o;
   logic        fetch_fault_page_o;
   logic        fetch_accept_i;

   modport master (
      output icache_rd_o, icache_pc_o,
      input  icache_accept_i, icache_valid_i, icache_inst_i,
             icache_error_i, icache_page_fault_i,
      output fetch_valid_o, fetch_instr_o, fetch_pc_o, fetch_pred_branch_o,
             fetch_fault_fetch_o, fetch_fault_page_o,
      input  fetch_accept_i
   );

   modport slave (
      input  icache_rd_o, icache_pc_o,
      output icache_accept_i, icache_valid_i, icache_inst_i,
             icache_error_i, icache_page_fault_i,
      input  fetch_valid_o, fetch_instr_o, fetch_pc_o, fetch_pred_branch_o,
             fetch_fault_fetch_o, fetch_fault_page_o,
      output fetch_accept_i
   );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: issues one 64-bit aligned icache read at a time,
// forwards the returned instruction pair to decode through a one-entry skid
// buffer, and handles redirects by dropping stale responses.
// Optional feature: define FETCH_BPRED_EN to follow the branch predictor's
// next PC and taken flags; otherwise fetch is purely sequential.
module fetch_pc_gen #(
   parameter logic [31:0] BOOT_VECTOR = 32'h80000000
) (
   input  logic                  clk_i,
   input  logic                  rst_n,
   input  logic                  branch_request_i,
   input  logic [31:0]           branch_pc_i,
   input  logic [31:0]           next_pc_f_i,
   input  logic [1:0]            next_taken_f_i,
   output logic [31:0]           pc_f_o,
   output logic                  pc_accept_o,
   fetch_pc_gen_if.master        bus
);

   logic        active_q;
   logic        outstanding_q;
   logic        discard_q;
   logic [31:0] pc_q;
   logic [31:0] pend_pc_q;
   logic [1:0]  pend_pred_q;

   logic        skid_valid_q;
   logic [63:0] skid_instr_q;
   logic [31:0] skid_pc_q;
   logic [1:0]  skid_pred_q;
   logic        skid_err_q;
   logic        skid_pf_q;

   logic        resp_valid;
   logic        resp_live;
   logic        skid_fill;
   logic        rd;
   logic        accept;
   logic [31:0] next_pc;
   logic [1:0]  next_pred;

   // A response only counts when it answers a request issued since reset;
   // anything else belongs to a request abandoned by reset.
   assign resp_valid = bus.icache_valid_i & outstanding_q;
   assign resp_live  = resp_valid & ~discard_q & ~branch_request_i;
   assign skid_fill  = resp_live & ~bus.fetch_accept_i;

   // Stall while the skid holds a bundle, and also in the cycle it is being
   // filled, otherwise the following response would find the skid occupied.
   assign rd     = active_q & ~skid_valid_q & ~skid_fill
                 & ~(outstanding_q & ~bus.icache_valid_i) & ~branch_request_i;
   assign accept = rd & bus.icache_accept_i;

`ifdef FETCH_BPRED_EN
   assign next_pc   = next_pc_f_i;
   assign next_pred = next_taken_f_i;
`else
   logic unused_pred;
   assign next_pc     = {pc_q[31:3] + 29'd1, 3'b000};
   assign next_pred   = 2'b00;
   assign unused_pred = ^{next_pc_f_i, next_taken_f_i};
`endif

   assign pc_f_o          = pc_q;
   assign pc_accept_o     = accept;
   assign bus.icache_rd_o = rd;
   assign bus.icache_pc_o = {pc_q[31:3], 3'b000};

   // Request bookkeeping: start-up, single outstanding request, discard flag.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of its neighbours, regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         active_q      <= 1'b0;
         outstanding_q <= 1'b0;
         discard_q     <= 1'b0;
      end else begin
         active_q <= 1'b1;
         if (accept)
            outstanding_q <= 1'b1;
         else if (resp_valid)
            outstanding_q <= 1'b0;
         if (branch_request_i && outstanding_q && !resp_valid)
            discard_q <= 1'b1;
         else if (resp_valid)
            discard_q <= 1'b0;
      end
   end

   // Fetch PC and the pending copy of the request currently in flight.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= BOOT_VECTOR;
         pend_pc_q   <= 32'h0;
         pend_pred_q <= 2'b00;
      end else begin
         if (branch_request_i)
            pc_q <= branch_pc_i;
         else if (accept)
            pc_q <= next_pc;
         if (accept) begin
            pend_pc_q   <= pc_q;
            pend_pred_q <= next_pred;
         end
      end
   end

   // Skid buffer: holds a response that decode could not take this cycle.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         skid_valid_q <= 1'b0;
         skid_instr_q <= 64'h0;
         skid_pc_q    <= 32'h0;
         skid_pred_q  <= 2'b00;
         skid_err_q   <= 1'b0;
         skid_pf_q    <= 1'b0;
      end else if (branch_request_i) begin
         skid_valid_q <= 1'b0;
      end else if (skid_fill) begin
         skid_valid_q <= 1'b1;
         skid_instr_q <= bus.icache_inst_i;
         skid_pc_q    <= pend_pc_q;
         skid_pred_q  <= pend_pred_q;
         skid_err_q   <= bus.icache_error_i;
         skid_pf_q    <= bus.icache_page_fault_i;
      end else if (bus.fetch_accept_i) begin
         skid_valid_q <= 1'b0;
      end
   end

   // Bundle towards decode: skid first, else the live response, else zeros.
   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      bus.fetch_valid_o       = skid_valid_q | resp_live;
      bus.fetch_instr_o       = 64'h0;
      bus.fetch_pc_o          = 32'h0;
      bus.fetch_pred_branch_o = 2'b00;
      bus.fetch_fault_fetch_o = 1'b0;
      bus.fetch_fault_page_o  = 1'b0;
      if (skid_valid_q) begin
         bus.fetch_instr_o       = skid_instr_q;
         bus.fetch_pc_o          = skid_pc_q;
         bus.fetch_pred_branch_o = skid_pred_q;
         bus.fetch_fault_fetch_o = skid_err_q;
         bus.fetch_fault_page_o  = skid_pf_q;
      end else if (resp_live) begin
         bus.fetch_instr_o       = bus.icache_inst_i;
         bus.fetch_pc_o          = pend_pc_q;
         bus.fetch_pred_branch_o = pend_pred_q;
         bus.fetch_fault_fetch_o = bus.icache_error_i;
         bus.fetch_fault_page_o  = bus.icache_page_fault_i;
      end
   end

endmodule
